// File: rtl/rl_force_accumulator.sv
// rl_force_accumulator
// Consumer end of the range-limited force pipeline. Sums NEIGHBOR_PARTICLE_NUM
// consecutive valid signed force samples per reference particle and writes
// one saturated total per reference particle into the force RAM.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse that arms (or restarts) a run
//   force_in        signed force sample (FORCE_WIDTH)
//   force_in_valid  force_in is valid this cycle (no backpressure)
//   wr_en           force RAM write strobe, one cycle per reference particle
//   wr_addr         reference particle index of the write
//   wr_data         accumulated (clamped) force total
//   busy            high while accumulating
//   done            one-cycle pulse after the last write of a run
//   saturated       sticky: some accumulation was clipped
//   dropped         sticky: a valid sample arrived outside accumulation
module rl_force_accumulator #(
  parameter int FORCE_WIDTH           = 32,
  parameter int ACC_WIDTH             = 40,
  parameter int REF_PARTICLE_NUM      = 100,
  parameter int REF_RAM_ADDR_WIDTH    = 7,
  parameter int NEIGHBOR_PARTICLE_NUM = 100,
  parameter int NEIGHBOR_CNT_WIDTH    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [FORCE_WIDTH-1:0]        force_in,
  input  logic                          force_in_valid,
  output logic                          wr_en,
  output logic [REF_RAM_ADDR_WIDTH-1:0] wr_addr,
  output logic [ACC_WIDTH-1:0]          wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          saturated,
  output logic                          dropped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [NEIGHBOR_CNT_WIDTH-1:0] NBR_LAST =
    NEIGHBOR_CNT_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);
  localparam logic [REF_RAM_ADDR_WIDTH-1:0] REF_LAST =
    REF_RAM_ADDR_WIDTH'(REF_PARTICLE_NUM - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
  localparam logic [NEIGHBOR_CNT_WIDTH-1:0] NBR_ZERO = {NEIGHBOR_CNT_WIDTH{1'b0}};
  localparam logic [REF_RAM_ADDR_WIDTH-1:0] REF_ZERO = {REF_RAM_ADDR_WIDTH{1'b0}};

  // One guard bit above the accumulator so a single add can never wrap.
  function automatic logic [ACC_WIDTH:0] add_wide(
    input logic [ACC_WIDTH-1:0]   acc,
    input logic [FORCE_WIDTH-1:0] f
  );
    return {acc[ACC_WIDTH-1], acc} +
           {{(ACC_WIDTH+1-FORCE_WIDTH){f[FORCE_WIDTH-1]}}, f};
  endfunction

  // Overflow shows up as the guard bit disagreeing with the accumulator sign.
  function automatic logic sum_clips(input logic [ACC_WIDTH:0] sum);
    return sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  endfunction

  // The guard bit holds the true sign, so it selects which rail to clamp to.
  function automatic logic [ACC_WIDTH-1:0] clamp_sum(input logic [ACC_WIDTH:0] sum);
    logic [ACC_WIDTH-1:0] res;
    if (sum_clips(sum)) begin
      res = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      res = sum[ACC_WIDTH-1:0];
    end
    return res;
  endfunction

  state_t                          state_r, state_s;
  logic [ACC_WIDTH-1:0]            acc_r, acc_s, acc_base_s;
  logic [NEIGHBOR_CNT_WIDTH-1:0]   nbr_cnt_r, nbr_cnt_s, nbr_base_s;
  logic [REF_RAM_ADDR_WIDTH-1:0]   ref_idx_r, ref_idx_s, ref_base_s;
  logic [ACC_WIDTH:0]              sum_s;
  logic [ACC_WIDTH-1:0]            clamped_s;
  logic                            clip_s;
  logic                            take_s;
  logic                            wr_en_r, wr_en_s;
  logic [REF_RAM_ADDR_WIDTH-1:0]   wr_addr_r, wr_addr_s;
  logic [ACC_WIDTH-1:0]            wr_data_r, wr_data_s;
  logic                            busy_r;
  logic                            done_r, done_s;
  logic                            saturated_r, saturated_s;
  logic                            dropped_r, dropped_s;

  // Next-state, datapath and output decode.
  always_comb begin
    // start wipes the run context in every state, so a sample taken in the
    // same cycle (only possible in ACCUM) becomes the first of the new run.
    acc_base_s = start ? ACC_ZERO : acc_r;
    nbr_base_s = start ? NBR_ZERO : nbr_cnt_r;
    ref_base_s = start ? REF_ZERO : ref_idx_r;

    sum_s     = add_wide(acc_base_s, force_in);
    clip_s    = sum_clips(sum_s);
    clamped_s = clamp_sum(sum_s);
    take_s    = (state_r == ST_ACCUM) && force_in_valid;

    state_s   = state_r;
    acc_s     = acc_base_s;
    nbr_cnt_s = nbr_base_s;
    ref_idx_s = ref_base_s;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    done_s    = 1'b0;

    saturated_s = (start ? 1'b0 : saturated_r) | (take_s & clip_s);
    dropped_s   = (start ? 1'b0 : dropped_r) |
                  (force_in_valid & (state_r != ST_ACCUM));

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (take_s) begin
          if (nbr_base_s == NBR_LAST) begin
            wr_en_s   = 1'b1;
            wr_addr_s = ref_base_s;
            wr_data_s = clamped_s;
            acc_s     = ACC_ZERO;
            nbr_cnt_s = NBR_ZERO;
            ref_idx_s = ref_base_s + REF_RAM_ADDR_WIDTH'(1);
            if (ref_base_s == REF_LAST) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_ACCUM;
            end
          end else begin
            acc_s     = clamped_s;
            nbr_cnt_s = nbr_base_s + NEIGHBOR_CNT_WIDTH'(1);
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        // The write for the final particle is visible now; done follows it.
        done_s = 1'b1;
        if (start) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= ACC_ZERO;
      nbr_cnt_r   <= NBR_ZERO;
      ref_idx_r   <= REF_ZERO;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= REF_ZERO;
      wr_data_r   <= ACC_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      saturated_r <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      nbr_cnt_r   <= nbr_cnt_s;
      ref_idx_r   <= ref_idx_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      busy_r      <= (state_s == ST_ACCUM);
      done_r      <= done_s;
      saturated_r <= saturated_s;
      dropped_r   <= dropped_s;
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign saturated = saturated_r;
  assign dropped   = dropped_r;

endmodule

// File: tb/tb_rl_force_accumulator.sv
// Randomized and directed bench for rl_force_accumulator against a
// cycle-level behavioural model built from integer arithmetic.
module tb_rl_force_accumulator;

  localparam int FW  = 32;
  localparam int AW  = 33;
  localparam int REF = 3;
  localparam int NBR = 4;
  localparam int RAW = 2;
  localparam int NCW = 2;

  localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (AW - 1));

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [FW-1:0]  force_in = '0;
  logic           force_in_valid = 1'b0;
  logic           wr_en;
  logic [RAW-1:0] wr_addr;
  logic [AW-1:0]  wr_data;
  logic           busy;
  logic           done;
  logic           saturated;
  logic           dropped;

  rl_force_accumulator #(
    .FORCE_WIDTH(FW), .ACC_WIDTH(AW), .REF_PARTICLE_NUM(REF),
    .REF_RAM_ADDR_WIDTH(RAW), .NEIGHBOR_PARTICLE_NUM(NBR),
    .NEIGHBOR_CNT_WIDTH(NCW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .force_in(force_in),
    .force_in_valid(force_in_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .saturated(saturated),
    .dropped(dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_count = 0;

  // model state
  bit     m_run = 0, m_fin = 0, m_sat = 0, m_drop = 0;
  longint m_sum = 0;
  int     m_cnt = 0, m_ref = 0;
  logic           exp_wr_en = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
  logic [RAW-1:0] exp_wr_addr = '0;
  logic [AW-1:0]  exp_wr_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sum = 0; m_cnt = 0; m_ref = 0; m_sat = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input logic [FW-1:0] f);
    longint sum;
    bit     new_fin;
    if (r) begin
      model_clear();
      m_run = 0; m_fin = 0;
      exp_wr_en = 0; exp_wr_addr = '0; exp_wr_data = '0;
      exp_done = 0; exp_busy = 0;
    end else begin
      exp_done  = m_fin;
      exp_wr_en = 0;
      new_fin   = 0;
      if (m_run && !m_fin) begin
        if (s) model_clear();
        if (v) begin
          sum = m_sum + longint'($signed(f));
          if (sum > MAXV) begin sum = MAXV; m_sat = 1; end
          else if (sum < MINV) begin sum = MINV; m_sat = 1; end
          m_cnt++;
          if (m_cnt == NBR) begin
            exp_wr_en   = 1;
            exp_wr_addr = m_ref[RAW-1:0];
            exp_wr_data = sum[AW-1:0];
            m_sum = 0; m_cnt = 0; m_ref++;
            if (m_ref == REF) begin
              m_run = 0; new_fin = 1;
            end
          end else begin
            m_sum = sum;
          end
        end
      end else begin
        // idle or the cycle right after the final write
        if (s) begin model_clear(); m_run = 1; end
        if (v) m_drop = 1;
      end
      m_fin    = new_fin;
      exp_busy = m_run;
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit v, input logic [FW-1:0] f);
    rst = r; start = s; force_in_valid = v; force_in = f;
    model_step(r, s, v, f);
    @(posedge clk);
    #1;
    check_eq("wr_en", 64'(wr_en), 64'(exp_wr_en));
    check_eq("wr_addr", 64'(wr_addr), 64'(exp_wr_addr));
    check_eq("wr_data", 64'(wr_data), 64'(exp_wr_data));
    check_eq("done", 64'(done), 64'(exp_done));
    check_eq("busy", 64'(busy), 64'(exp_busy));
    check_eq("saturated", 64'(saturated), 64'(m_sat));
    check_eq("dropped", 64'(dropped), 64'(m_drop));
    if (wr_en === 1'b1) wr_count++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
  endtask

  initial begin
    logic [FW-1:0] mix [4];
    logic [FW-1:0] big;
    mix[0] = 32'd5; mix[1] = -32'sd3; mix[2] = -32'sd7; mix[3] = 32'd2;
    big = 32'h7FFF_FFFF;

    // reset state
    cyc(1, 0, 0, '0);
    cyc(1, 0, 0, '0);
    idle(2);

    // back-to-back +1 run
    wr_count = 0;
    cyc(0, 1, 0, '0);
    for (int i = 0; i < REF * NBR; i++) cyc(0, 0, 1, 32'd1);
    idle(4);
    check_eq("run1_writes", 64'(wr_count), 64'd3);

    // mixed signs with random valid gaps
    wr_count = 0;
    cyc(0, 1, 0, '0);
    for (int p = 0; p < REF; p++) begin
      for (int k = 0; k < NBR; k++) begin
        cyc(0, 0, 1, mix[k]);
        idle($urandom_range(1, 3));
      end
    end
    idle(3);
    check_eq("run2_writes", 64'(wr_count), 64'd3);
    check_eq("run2_sat", 64'(saturated), 64'd0);

    // saturation, then start clears the flag
    cyc(0, 1, 0, '0);
    for (int k = 0; k < NBR; k++) cyc(0, 0, 1, big);
    idle(1);
    check_eq("sat_set", 64'(saturated), 64'd1);
    cyc(0, 1, 0, '0);
    check_eq("sat_clear", 64'(saturated), 64'd0);

    // restart mid-particle with +2 samples
    for (int k = 0; k < NBR + 2; k++) cyc(0, 0, 1, 32'd1);
    cyc(0, 1, 0, '0);
    for (int k = 0; k < NBR; k++) cyc(0, 0, 1, 32'd2);
    idle(1);
    // finish that run to reach DONE, with samples hitting the done window
    for (int k = 0; k < (REF - 1) * NBR; k++) cyc(0, 0, 1, 32'd1);
    cyc(0, 0, 1, 32'd9);
    cyc(0, 0, 1, 32'd9);
    idle(2);
    check_eq("drop_set", 64'(dropped), 64'd1);

    // samples before start, then start clears
    cyc(0, 0, 1, 32'd4);
    cyc(0, 1, 0, '0);
    check_eq("drop_clear", 64'(dropped), 64'd0);

    // reset in the middle of a run, then a full clean run
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 32'd1);
    cyc(1, 0, 1, 32'd1);
    cyc(1, 0, 0, '0);
    idle(1);
    wr_count = 0;
    cyc(0, 1, 0, '0);
    for (int i = 0; i < REF * NBR; i++) cyc(0, 0, 1, 32'd3);
    idle(3);
    check_eq("run_after_rst_writes", 64'(wr_count), 64'd3);

    // start coinciding with a valid sample, and start during DONE
    cyc(0, 1, 0, '0);
    cyc(0, 0, 1, 32'd1);
    cyc(0, 1, 1, 32'd6);
    for (int i = 0; i < REF * NBR - 1; i++) cyc(0, 0, 1, 32'd1);
    cyc(0, 1, 0, '0);
    for (int i = 0; i < REF * NBR; i++) cyc(0, 0, 1, 32'd2);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, s, v;
      logic [FW-1:0] f;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) f = $urandom();
      else f = FW'($signed($urandom_range(0, 200)) - 100);
      cyc(r, s, v, f);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
